// File: rtl/ram_controller_pkg.sv
// Shared types and constants for the RAM controller slice: state encoding,
// word width and byte-to-word address shift.
package ram_controller_pkg;

  localparam int WORD_BITS  = 32;
  localparam int BYTE_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_controller_if.sv
// Core-to-RAM request/acknowledge bus plus the program-load port.
interface ram_controller_if #(
  parameter int ADDR_BITS = 10
);
  import ram_controller_pkg::*;

  logic [WORD_BITS-1:0] reqAddress;
  logic [WORD_BITS-1:0] writeData;
  logic                 readReq;
  logic                 writeReq;
  logic [WORD_BITS-1:0] readData;
  logic                 readAck;
  logic                 writeAck;
  logic                 busy;
  logic                 protErr;
  logic                 loadEn;
  logic [ADDR_BITS-1:0] loadAddr;
  logic [WORD_BITS-1:0] loadData;

  modport master (
    output reqAddress, writeData, readReq, writeReq, loadEn, loadAddr, loadData,
    input  readData, readAck, writeAck, busy, protErr
  );

  modport slave (
    input  reqAddress, writeData, readReq, writeReq, loadEn, loadAddr, loadData,
    output readData, readAck, writeAck, busy, protErr
  );

endinterface

// File: rtl/ram_word_array.sv
// Single-port 32-bit word RAM with registered read; contents are never reset.
module ram_word_array
  import ram_controller_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] widx,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    rdata <= mem[widx];
  end

endmodule

// File: rtl/ram_controller.sv
// RAM-side slave for the core request bus: wait-state sequencer, word RAM and load port.
//   state   | meaning
//   ST_IDLE | accept a request or a program-load write
//   ST_WAIT | wait-state countdown, request latched
//   ST_ACK  | commit write / capture read word; ack pulses in the following cycle
module ram_controller
  import ram_controller_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2
) (
  input logic clk,
  input logic reset,
  ram_controller_if.slave bus
);

  state_t               state, nextState;
  logic [3:0]           waitCnt, nextWaitCnt;
  logic [ADDR_BITS-1:0] wordIdxQ;
  logic [WORD_BITS-1:0] dataQ;
  logic                 isWriteQ;
  logic                 outOfRangeQ;
  logic                 req, capture, loadHonoured, reqOutOfRange;
  logic [WORD_BITS-1:0] readDataQ;
  logic                 readAckQ, writeAckQ, busyQ, protErrQ;
  logic                 ramWe;
  logic [ADDR_BITS-1:0] ramIdx;
  logic [WORD_BITS-1:0] ramWdata, ramRdata;

  assign req           = bus.readReq | bus.writeReq;
  assign capture       = (state == ST_IDLE) && req;
  assign loadHonoured  = (state == ST_IDLE) && !req && !busyQ && bus.loadEn;
  assign reqOutOfRange = |(bus.reqAddress >> (ADDR_BITS + BYTE_SHIFT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
    end
  end

  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            nextState = ST_ACK;
          end else begin
            nextState   = ST_WAIT;
            nextWaitCnt = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        nextWaitCnt = waitCnt - 4'd1;
        if (waitCnt == 4'd1) nextState = ST_ACK;
      end
      ST_ACK: begin
        nextState   = ST_IDLE;
        nextWaitCnt = '0;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // In IDLE the read port already follows the incoming request so that the
  // registered read word is ready by ACK even with zero wait states.
  always_comb begin
    ramWe    = 1'b0;
    ramIdx   = bus.loadAddr;
    ramWdata = bus.loadData;
    if (state != ST_IDLE) begin
      ramIdx   = wordIdxQ;
      ramWdata = dataQ;
      ramWe    = (state == ST_ACK) && isWriteQ && !outOfRangeQ;
    end else if (req) begin
      ramIdx = bus.reqAddress[ADDR_BITS+BYTE_SHIFT-1:BYTE_SHIFT];
    end else begin
      ramWe = loadHonoured;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wordIdxQ    <= '0;
      dataQ       <= '0;
      isWriteQ    <= 1'b0;
      outOfRangeQ <= 1'b0;
      readDataQ   <= '0;
      readAckQ    <= 1'b0;
      writeAckQ   <= 1'b0;
      busyQ       <= 1'b0;
      protErrQ    <= 1'b0;
    end else begin
      readAckQ  <= 1'b0;
      writeAckQ <= 1'b0;
      if (capture) begin
        wordIdxQ    <= bus.reqAddress[ADDR_BITS+BYTE_SHIFT-1:BYTE_SHIFT];
        dataQ       <= bus.writeData;
        isWriteQ    <= bus.writeReq;
        outOfRangeQ <= reqOutOfRange;
      end
      if (state == ST_ACK) begin
        if (isWriteQ) begin
          writeAckQ <= 1'b1;
        end else begin
          readAckQ  <= 1'b1;
          readDataQ <= outOfRangeQ ? '0 : ramRdata;
        end
      end
      // busy spans capture through the cycle in which the ack is visible
      busyQ <= (nextState != ST_IDLE) || (state == ST_ACK);
      if ((capture && bus.readReq && bus.writeReq) ||
          ((state == ST_WAIT) && req) ||
          (bus.loadEn && busyQ) ||
          ((state == ST_ACK) && outOfRangeQ))
        protErrQ <= 1'b1;
    end
  end

  ram_word_array #(.ADDR_BITS(ADDR_BITS)) uRam (
    .clk  (clk),
    .we   (ramWe),
    .widx (ramIdx),
    .wdata(ramWdata),
    .rdata(ramRdata)
  );

  assign bus.readData = readDataQ;
  assign bus.readAck  = readAckQ;
  assign bus.writeAck = writeAckQ;
  assign bus.busy     = busyQ;
  assign bus.protErr  = protErrQ;

endmodule

// File: tb/tb_ram_controller.sv
// Directed self-checking bench for ram_controller (ADDR_BITS=10, WAIT_STATES=2).
module tb_ram_controller;
  import ram_controller_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ackCount;

  ram_controller_if #(.ADDR_BITS(10)) bus ();

  ram_controller #(.ADDR_BITS(10), .WAIT_STATES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    tick();
    check("rst_readData", bus.readData, 32'h0);
    check("rst_acks", {30'h0, bus.readAck, bus.writeAck}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_protErr", {31'h0, bus.protErr}, 32'h0);
    reset = 1'b1;
    tick();
  endtask

  task automatic loadWord(input logic [9:0] idx, input logic [31:0] data);
    bus.loadEn   = 1'b1;
    bus.loadAddr = idx;
    bus.loadData = data;
    tick();
    bus.loadEn = 1'b0;
  endtask

  // Issue a one-cycle request and check busy, ack latency (capture + 3) and ack kind.
  task automatic runOp(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic expRead, input logic expWrite);
    bus.readReq    = rd;
    bus.writeReq   = wr;
    bus.reqAddress = addr;
    bus.writeData  = data;
    tick();
    bus.readReq  = 1'b0;
    bus.writeReq = 1'b0;
    check({tag, "_busy_cap"}, {31'h0, bus.busy}, 32'h1);
    for (int c = 1; c <= 2; c++) begin
      tick();
      check({tag, "_no_early_ack"}, {30'h0, bus.readAck, bus.writeAck}, 32'h0);
    end
    tick();
    check({tag, "_ack"}, {30'h0, bus.readAck, bus.writeAck}, {30'h0, expRead, expWrite});
    check({tag, "_busy_ack"}, {31'h0, bus.busy}, 32'h1);
    tick();
    check({tag, "_ack_off"}, {30'h0, bus.readAck, bus.writeAck}, 32'h0);
    check({tag, "_busy_off"}, {31'h0, bus.busy}, 32'h0);
  endtask

  initial begin
    bus.reqAddress = '0;
    bus.writeData  = '0;
    bus.readReq    = 1'b0;
    bus.writeReq   = 1'b0;
    bus.loadEn     = 1'b0;
    bus.loadAddr   = '0;
    bus.loadData   = '0;
    #2;
    applyReset();

    // load then fetch
    loadWord(10'd0, 32'h0000_0101);
    loadWord(10'd1, 32'h0000_002A);
    check("load_no_ack", {30'h0, bus.readAck, bus.writeAck}, 32'h0);
    runOp("rd4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);
    check("rd4_data", bus.readData, 32'h0000_002A);
    runOp("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("rd0_data", bus.readData, 32'h0000_0101);

    // write / read-back with ignored low address bits
    runOp("wr40", 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1);
    runOp("rd43", 1'b1, 1'b0, 32'h43, 32'h0, 1'b1, 1'b0);
    check("rd43_data", bus.readData, 32'hDEAD_BEEF);
    runOp("wr44", 1'b0, 1'b1, 32'h44, 32'h1, 1'b0, 1'b1);
    check("hold_after_write", bus.readData, 32'hDEAD_BEEF);
    check("no_err_yet", {31'h0, bus.protErr}, 32'h0);

    // out of range read, protErr sticky
    runOp("rd1000", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 1'b0);
    check("oor_data", bus.readData, 32'h0);
    check("oor_err", {31'h0, bus.protErr}, 32'h1);
    runOp("rd4b", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0);
    check("rd4b_data", bus.readData, 32'h0000_002A);
    check("oor_err_sticky", {31'h0, bus.protErr}, 32'h1);

    // read/write collision: write wins
    applyReset();
    runOp("coll", 1'b1, 1'b1, 32'h8, 32'h55, 1'b0, 1'b1);
    check("coll_err", {31'h0, bus.protErr}, 32'h1);
    runOp("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0);
    check("rd8_data", bus.readData, 32'h55);

    // second request while waiting
    applyReset();
    bus.readReq    = 1'b1;
    bus.reqAddress = 32'h4;
    tick();
    check("busyv_busy", {31'h0, bus.busy}, 32'h1);
    tick();
    bus.readReq = 1'b0;
    ackCount = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.readAck) ackCount++;
      tick();
    end
    check("busyv_one_ack", ackCount, 32'd1);
    check("busyv_err", {31'h0, bus.protErr}, 32'h1);
    check("busyv_data", bus.readData, 32'h0000_002A);

    // reset in the middle of a write
    applyReset();
    loadWord(10'd3, 32'h0000_0033);
    runOp("rdC", 1'b1, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0);
    check("rdC_data", bus.readData, 32'h0000_0033);
    bus.writeReq   = 1'b1;
    bus.reqAddress = 32'hC;
    bus.writeData  = 32'h77;
    tick();
    bus.writeReq = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_readData", bus.readData, 32'h0);
    check("midrst_acks", {30'h0, bus.readAck, bus.writeAck}, 32'h0);
    check("midrst_busy", {31'h0, bus.busy}, 32'h0);
    check("midrst_err", {31'h0, bus.protErr}, 32'h0);
    tick();
    reset = 1'b1;
    ackCount = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.writeAck) ackCount++;
    end
    check("midrst_no_wack", ackCount, 32'd0);
    runOp("rdC2", 1'b1, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0);
    check("rdC2_old", bus.readData, 32'h0000_0033);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
